// File: rtl/octagon_motion_ctrl_pkg.sv
// Shared definitions for the octagon motion controller: FSM encoding,
// coordinate width, default motion parameters and the output packer.
package octagon_pkg;

  // Controller modes: frozen, self-bouncing, push-button steered.
  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_AUTO = 2'd1,
    S_MAN  = 2'd2
  } state_t;

  // Internal coordinates are signed two's complement, wide enough for +/-255.
  localparam int POS_W = 9;

  localparam int         DEF_STEP      = 4;
  localparam int         DEF_X_LIM     = 255;
  localparam int         DEF_Y_LIM     = 150;
  localparam int         DEF_FRAME_DIV = 1;
  localparam logic [7:0] DEF_COLOR_INC = 8'h13;

  // Converts the signed coordinates into the renderer's sign-magnitude word.
  // A zero coordinate is always reported as +0.
  function automatic logic [31:0] pack_position(
    input logic signed [POS_W-1:0] x,
    input logic signed [POS_W-1:0] y,
    input logic [7:0]              colour
  );
    logic [7:0] mag_x;
    logic [7:0] mag_y;
    mag_x = x[POS_W-1] ? 8'(-x) : 8'(x);
    mag_y = y[POS_W-1] ? 8'(-y) : 8'(y);
    return {~x[POS_W-1], ~y[POS_W-1], 6'd0, mag_x, mag_y, colour};
  endfunction

endpackage

// File: rtl/octagon_motion_ctrl_sync_edge.sv
// Two-flop synchroniser for one asynchronous input, with single-cycle
// rise and fall pulses derived from the synchronised level.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  // Resample the raw input twice, then keep one more stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
      prev_reg <= 1'b0;
    end else begin
      meta_reg <= din;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign level = sync_reg;
  assign rise  = sync_reg & ~prev_reg;
  assign fall  = ~sync_reg & prev_reg;

endmodule

// File: rtl/octagon_motion_ctrl.sv
// Octagon motion controller: moves the renderer's octagon once per frame
// (on the falling edge of vertical sync), either bouncing between limits
// or steered by buttons, and presents a registered position/colour word
// that only changes shortly after the sync edge.
module octagon_motion_ctrl
  import octagon_pkg::*;
#(
  parameter int         STEP      = DEF_STEP,
  parameter int         X_LIM     = DEF_X_LIM,
  parameter int         Y_LIM     = DEF_Y_LIM,
  parameter int         FRAME_DIV = DEF_FRAME_DIV,
  parameter logic [7:0] COLOR_INC = DEF_COLOR_INC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vga_vs,
  input  logic        sw_auto,
  input  logic        btn_c,
  input  logic        btn_u,
  input  logic        btn_d,
  input  logic        btn_l,
  input  logic        btn_r,
  output logic [31:0] position
);

  // Headroom so x+step never wraps before it is compared with the limit.
  localparam int CW   = POS_W + 2;
  localparam int N_IN = 7;

  // ---------------------------------------------------------------------
  // Reset: asserted immediately, released in step with the clock.
  // ---------------------------------------------------------------------
  logic rst_meta_reg;
  logic rst_sync_reg;
  logic rst_n_int;

  // Two-flop reset release so every flop leaves reset on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_meta_reg <= 1'b0;
      rst_sync_reg <= 1'b0;
    end else begin
      rst_meta_reg <= 1'b1;
      rst_sync_reg <= rst_meta_reg;
    end
  end

  assign rst_n_int = rst_sync_reg;

  // ---------------------------------------------------------------------
  // Input conditioning. Bit order: vs, c, u, d, l, r, sw_auto.
  // ---------------------------------------------------------------------
  logic [N_IN-1:0] raw_in;
  logic [N_IN-1:0] in_level;
  logic [N_IN-1:0] in_rise;
  logic [N_IN-1:0] in_fall;
  logic            unused_edges;

  assign raw_in = {sw_auto, btn_r, btn_l, btn_d, btn_u, btn_c, vga_vs};

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_sync
    sync_edge u_sync (
      .clk   (clk),
      .rst_n (rst_n_int),
      .din   (raw_in[gi]),
      .level (in_level[gi]),
      .rise  (in_rise[gi]),
      .fall  (in_fall[gi])
    );
  end

  logic vs_fall;
  logic btn_c_rise;
  logic sw_auto_lvl;
  logic [1:0] plus_lvl;   // [0] right (+x), [1] down (+y)
  logic [1:0] minus_lvl;  // [0] left (-x),  [1] up (-y)

  assign vs_fall     = in_fall[0];
  assign btn_c_rise  = in_rise[1];
  assign sw_auto_lvl = in_level[6];
  assign plus_lvl    = {in_level[3], in_level[5]};
  assign minus_lvl   = {in_level[2], in_level[4]};

  // Edge/level outputs this block never looks at.
  assign unused_edges = ^{in_level[1:0], in_rise[6:2], in_rise[0], in_fall[6:1]};

  // ---------------------------------------------------------------------
  // Mode FSM
  // ---------------------------------------------------------------------
  state_t state_reg;
  state_t state_next;

  // Mode register.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_reg <= S_HOLD;
    end else begin
      state_reg <= state_next;
    end
  end

  // Pause/resume on the centre button; the switch picks auto or manual.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_HOLD: begin
        if (btn_c_rise) begin
          state_next = sw_auto_lvl ? S_AUTO : S_MAN;
        end
      end
      S_AUTO: begin
        if (btn_c_rise) begin
          state_next = S_HOLD;
        end else if (!sw_auto_lvl) begin
          state_next = S_MAN;
        end
      end
      S_MAN: begin
        if (btn_c_rise) begin
          state_next = S_HOLD;
        end else if (sw_auto_lvl) begin
          state_next = S_AUTO;
        end
      end
      default: state_next = S_HOLD;
    endcase
  end

  // ---------------------------------------------------------------------
  // Frame divider and step tick
  // ---------------------------------------------------------------------
  logic [7:0] div_reg;
  logic       div_wrap;
  logic       running;
  logic       step;

  assign running  = (state_reg != S_HOLD);
  assign div_wrap = (div_reg == 8'(FRAME_DIV - 1));
  assign step     = vs_fall && running && div_wrap;

  // Count frames while moving; the wrapping frame produces the step.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      div_reg <= 8'd0;
    end else if (vs_fall && running) begin
      div_reg <= div_wrap ? 8'd0 : div_reg + 8'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Per-axis datapath: index 0 is x, index 1 is y.
  // ---------------------------------------------------------------------
  logic [1:0] bounce;

  for (genvar gi = 0; gi < 2; gi++) begin : g_axis
    localparam int LIM = (gi == 0) ? X_LIM : Y_LIM;
    localparam logic signed [CW-1:0] LIM_P  = CW'(LIM);
    localparam logic signed [CW-1:0] LIM_N  = -CW'(LIM);
    localparam logic signed [CW-1:0] STEP_V = CW'(STEP);

    logic signed [POS_W-1:0] pos_reg;
    logic signed [POS_W-1:0] pos_next;
    logic                    vneg_reg;
    logic signed [CW-1:0]    cur;
    logic signed [CW-1:0]    delta;
    logic signed [CW-1:0]    sum;
    logic                    over_hi;
    logic                    over_lo;

    // Candidate coordinate for this step, clamped to the axis limit.
    always_comb begin
      cur   = {{(CW - POS_W){pos_reg[POS_W-1]}}, pos_reg};
      delta = '0;
      if (state_reg == S_AUTO) begin
        delta = vneg_reg ? -STEP_V : STEP_V;
      end else if (plus_lvl[gi] && !minus_lvl[gi]) begin
        delta = STEP_V;
      end else if (minus_lvl[gi] && !plus_lvl[gi]) begin
        delta = -STEP_V;
      end
      sum     = cur + delta;
      over_hi = (sum > LIM_P);
      over_lo = (sum < LIM_N);
      if (over_hi) begin
        pos_next = LIM_P[POS_W-1:0];
      end else if (over_lo) begin
        pos_next = LIM_N[POS_W-1:0];
      end else begin
        pos_next = sum[POS_W-1:0];
      end
    end

    // Only auto mode reflects off a limit; manual moves just clamp.
    assign bounce[gi] = (state_reg == S_AUTO) && (over_hi || over_lo);

    // Coordinate and direction advance only on a step tick.
    always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
        pos_reg  <= '0;
        vneg_reg <= 1'b0;
      end else if (step) begin
        pos_reg <= pos_next;
        if (bounce[gi]) begin
          vneg_reg <= ~vneg_reg;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Colour and output word
  // ---------------------------------------------------------------------
  logic [7:0]  colour_reg;
  logic        step_d_reg;
  logic [31:0] position_reg;

  // One colour advance per bouncing step, even if both axes hit a limit.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      colour_reg <= 8'h00;
    end else if (step && (|bounce)) begin
      colour_reg <= colour_reg + COLOR_INC;
    end
  end

  // Publish the new coordinates the cycle after they settle; no other cycle
  // touches the output so a frame never sees a half-updated word.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      step_d_reg   <= 1'b0;
      position_reg <= 32'hC000_0000;
    end else begin
      step_d_reg <= step;
      if (step_d_reg) begin
        position_reg <= pack_position(g_axis[0].pos_reg, g_axis[1].pos_reg, colour_reg);
      end
    end
  end

  assign position = position_reg;

endmodule

// File: tb/tb_octagon_motion_ctrl.sv
// Directed bench for octagon_motion_ctrl: a table of manual/auto step
// vectors with hand-computed output words, plus sequences for reset,
// output latency, double bounce, simultaneous pause/step and reset mid-move.
module tb_octagon_motion_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        vga_vs;
  logic        sw_auto;
  logic        btn_c;
  logic        btn_u;
  logic        btn_d;
  logic        btn_l;
  logic        btn_r;
  logic [31:0] position;

  int checks   = 0;
  int failures = 0;

  octagon_motion_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .vga_vs   (vga_vs),
    .sw_auto  (sw_auto),
    .btn_c    (btn_c),
    .btn_u    (btn_u),
    .btn_d    (btn_d),
    .btn_l    (btn_l),
    .btn_r    (btn_r),
    .position (position)
  );

  always #5 clk = ~clk;

  // btns = {u, d, l, r}
  typedef struct {
    logic        sw;
    logic [3:0]  btns;
    int          steps;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] exp);
    checks++;
    if (position !== exp) begin
      failures++;
      $display("FAIL %s: position=%h expected=%h", name, position, exp);
    end else begin
      $display("ok   %s: position=%h", name, position);
    end
  endtask

  task automatic frame();
    vga_vs = 1'b1;
    repeat (4) @(negedge clk);
    vga_vs = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  // Position must still hold prev three clocks after vga_vs drops
  // (sync'd fall + 1) and show exp on the fourth (sync'd fall + 2).
  task automatic frame_lat(input string name, input logic [31:0] prev, input logic [31:0] exp);
    vga_vs = 1'b1;
    repeat (4) @(negedge clk);
    vga_vs = 1'b0;
    repeat (3) @(negedge clk);
    check({name, "_early"}, prev);
    @(negedge clk);
    check(name, exp);
    repeat (2) @(negedge clk);
  endtask

  task automatic press_c();
    btn_c = 1'b1;
    repeat (4) @(negedge clk);
    btn_c = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic set_btns(input logic [3:0] b);
    {btn_u, btn_d, btn_l, btn_r} = b;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b0, 4'b0010,   1, 32'h4004_0000};
    vecs[1] = '{1'b0, 4'b0010,  69, 32'h40FF_0000};
    vecs[2] = '{1'b0, 4'b0011,   3, 32'h40FF_0000};
    vecs[3] = '{1'b0, 4'b1000,   2, 32'h00FF_0800};
    vecs[4] = '{1'b0, 4'b0100,   2, 32'h40FF_0000};
    vecs[5] = '{1'b0, 4'b1100,   2, 32'h40FF_0000};
    vecs[6] = '{1'b0, 4'b0101,  25, 32'h409B_6400};
    vecs[7] = '{1'b0, 4'b0001, 102, 32'hC0FD_6400};
    vecs[8] = '{1'b1, 4'b0000,   1, 32'hC0FF_6813};
    vecs[9] = '{1'b1, 4'b0000,   1, 32'hC0FB_6C13};

    rst = 1'b0; vga_vs = 1'b1; sw_auto = 1'b0;
    btn_c = 1'b0; set_btns(4'b0000);

    // Reset mid-frame, then frames while held.
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    vga_vs = 1'b0;
    repeat (6) @(negedge clk);
    check("reset_value", 32'hC000_0000);
    frames(10);
    check("hold_10_frames", 32'hC000_0000);

    // Auto run with output latency checks.
    sw_auto = 1'b1;
    press_c();
    frame_lat("auto_step1", 32'hC000_0000, 32'hC004_0400);
    frame_lat("auto_step2", 32'hC004_0400, 32'hC008_0800);
    frame_lat("auto_step3", 32'hC008_0800, 32'hC00C_0C00);
    press_c();
    frame();
    check("paused", 32'hC00C_0C00);

    // Pause pressed on the step cycle: step applies, then hold.
    press_c();
    vga_vs = 1'b1;
    repeat (4) @(negedge clk);
    vga_vs = 1'b0;
    btn_c  = 1'b1;
    repeat (6) @(negedge clk);
    btn_c = 1'b0;
    repeat (4) @(negedge clk);
    check("step_with_pause", 32'hC010_1000);
    frame();
    check("paused_after_step", 32'hC010_1000);

    // Reset arriving after the coordinate update but before the output update.
    press_c();
    vga_vs = 1'b1;
    repeat (4) @(negedge clk);
    vga_vs = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_pending", 32'hC010_1000);
    rst = 1'b0;
    #1;
    check("reset_mid_move", 32'hC000_0000);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    frame();
    check("after_reset_hold", 32'hC000_0000);

    // Manual clamp/cancel table, then auto bounce off +x.
    sw_auto = 1'b0;
    press_c();
    for (int v = 0; v < 10; v++) begin
      sw_auto = vecs[v].sw;
      set_btns(vecs[v].btns);
      frames(vecs[v].steps);
      check($sformatf("vec%0d", v), vecs[v].exp);
    end
    set_btns(4'b0000);

    // Both axes bounce in one step: colour advances once.
    sw_auto = 1'b0;
    do_reset();
    press_c();
    set_btns(4'b0010);
    frames(64);
    check("dbl_pre_left", 32'h40FF_0000);
    set_btns(4'b0101);
    frames(37);
    check("dbl_pre_rd", 32'h406B_9400);
    set_btns(4'b0001);
    frames(90);
    check("dbl_pre_r", 32'hC0FD_9400);
    set_btns(4'b0000);
    sw_auto = 1'b1;
    frame();
    check("double_bounce", 32'hC0FF_9613);
    frame();
    check("after_double_bounce", 32'hC0FB_9213);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
